// File: rtl/axis_packet_mux.sv
// N-input AXI-Stream packet multiplexer: grant is held for a whole packet and the
// output is a registered slice. Arbitration is an external select (MODE 0) or round-robin (MODE 1).
module axis_packet_mux #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int MODE       = 0,
  localparam int SEL_W     = $clog2(NUM_CH)
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]            s_axis_tvalid,
  input  logic [NUM_CH-1:0]            s_axis_tlast,
  output logic [NUM_CH-1:0]            s_axis_tready,
  input  logic [SEL_W-1:0]             sel,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  output logic [SEL_W-1:0]             m_axis_tid,
  input  logic                         m_axis_tready,
  output logic                         busy
);

  // Handshake: a beat moves on a port when tvalid and tready are both high at
  // the rising edge; a held m_axis beat keeps its payload stable until accepted.

  localparam int NPAD = 1 << SEL_W;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state, state_next;
  logic [SEL_W-1:0]      grant, grant_next;
  logic [SEL_W-1:0]      last_grant, last_grant_next;
  logic [NPAD-1:0]       valid_pad;
  logic [DATA_WIDTH-1:0] data_g;
  logic                  valid_g, last_g;
  logic                  room, accept;
  logic [SEL_W-1:0]      rr_pick, cand;
  logic                  rr_found;

  // Padding to a power of two makes an out-of-range sel read as "not valid".
  always_comb begin
    valid_pad = '0;
    valid_pad[NUM_CH-1:0] = s_axis_tvalid;
    data_g  = '0;
    valid_g = 1'b0;
    last_g  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == SEL_W'(i)) begin
        data_g  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        valid_g = s_axis_tvalid[i];
        last_g  = s_axis_tlast[i];
      end
    end
  end

  assign room   = !m_axis_tvalid || m_axis_tready;
  assign accept = (state == LOCKED) && valid_g && room;
  assign busy   = (state == LOCKED);

  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      s_axis_tready[i] = (state == LOCKED) && (grant == SEL_W'(i)) && room;
    end
  end

  // Round-robin search starts just after the last granted channel.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_grant;
    cand     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = SEL_W'((int'(last_grant) + k) % NUM_CH);
      if (!rr_found && valid_pad[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
    end
  end

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (MODE == 0) begin
          if (valid_pad[sel]) begin
            grant_next = sel;
            state_next = LOCKED;
          end
        end else if (rr_found) begin
          grant_next = rr_pick;
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && last_g) begin
          state_next      = IDLE;
          last_grant_next = grant;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SEL_W'(NUM_CH - 1);
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
    end else if (accept) begin
      m_axis_tdata  <= data_g;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= last_g;
      m_axis_tid    <= grant;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_packet_mux.sv
// Directed bench: a 3-channel external-select mux and a 4-channel round-robin mux.
module tb_axis_packet_mux;

  logic aclk;
  logic areset;

  // external-select instance, NUM_CH=3 so sel=3 is an invalid request
  logic [7:0]  da [3];
  logic [23:0] tdata_a;
  logic [2:0]  tvalid_a, tlast_a, tready_a;
  logic [1:0]  sel_a;
  logic [7:0]  m_data_a;
  logic        m_valid_a, m_last_a, m_ready_a, busy_a;
  logic [1:0]  m_tid_a;

  // round-robin instance, NUM_CH=4
  logic [7:0]  db [4];
  logic [31:0] tdata_b;
  logic [3:0]  tvalid_b, tlast_b, tready_b;
  logic [1:0]  sel_b;
  logic [7:0]  m_data_b;
  logic        m_valid_b, m_last_b, m_ready_b, busy_b;
  logic [1:0]  m_tid_b;

  int checks = 0;
  int errors = 0;

  assign tdata_a = {da[2], da[1], da[0]};
  assign tdata_b = {db[3], db[2], db[1], db[0]};

  axis_packet_mux #(.DATA_WIDTH(8), .NUM_CH(3), .MODE(0)) dut_a (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(tdata_a), .s_axis_tvalid(tvalid_a), .s_axis_tlast(tlast_a),
    .s_axis_tready(tready_a), .sel(sel_a),
    .m_axis_tdata(m_data_a), .m_axis_tvalid(m_valid_a), .m_axis_tlast(m_last_a),
    .m_axis_tid(m_tid_a), .m_axis_tready(m_ready_a), .busy(busy_a)
  );

  axis_packet_mux #(.DATA_WIDTH(8), .NUM_CH(4), .MODE(1)) dut_b (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(tdata_b), .s_axis_tvalid(tvalid_b), .s_axis_tlast(tlast_b),
    .s_axis_tready(tready_b), .sel(sel_b),
    .m_axis_tdata(m_data_b), .m_axis_tvalid(m_valid_b), .m_axis_tlast(m_last_b),
    .m_axis_tid(m_tid_b), .m_axis_tready(m_ready_b), .busy(busy_b)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_q [$];
  logic [1:0] tid_exp [$];
  logic [7:0] dat_got [$];
  logic [1:0] tid_got [$];
  logic       phase [4];
  logic [3:0] pre;
  int         got;

  task automatic drive_b;
    for (int i = 0; i < 4; i++) begin
      db[i]       = {4'(i), 3'b000, phase[i]};
      tlast_b[i]  = phase[i];
    end
  endtask

  initial begin
    areset = 1'b1;
    for (int i = 0; i < 3; i++) da[i] = 8'h00;
    tvalid_a = '0; tlast_a = '0; sel_a = '0; m_ready_a = 1'b1;
    for (int i = 0; i < 4; i++) phase[i] = 1'b0;
    tvalid_b = '0; sel_b = '0; m_ready_b = 1'b1;
    drive_b();
    repeat (2) @(posedge aclk);
    #1;
    check("rst_valid_a", m_valid_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_tready_a", tready_a, 0);
    check("rst_data_b", m_data_b, 0);
    check("rst_tid_b", m_tid_b, 0);
    areset = 1'b0;

    // 3-beat packet on channel 1
    sel_a = 2'd1; tvalid_a = 3'b010; da[1] = 8'hA1; tlast_a = 3'b000;
    tick;
    check("t1_busy", busy_a, 1);
    check("t1_tready", tready_a, 3'b010);
    check("t1_valid0", m_valid_a, 0);
    tick;
    check("t1_d1", m_data_a, 8'hA1);
    check("t1_tid1", m_tid_a, 1);
    check("t1_last1", m_last_a, 0);
    da[1] = 8'hA2;
    tick;
    check("t1_d2", m_data_a, 8'hA2);
    check("t1_last2", m_last_a, 0);
    da[1] = 8'hA3; tlast_a = 3'b010;
    tick;
    check("t1_d3", m_data_a, 8'hA3);
    check("t1_last3", m_last_a, 1);
    check("t1_busy_end", busy_a, 0);
    check("t1_tready_end", tready_a, 0);
    tvalid_a = '0; tlast_a = '0;
    tick;
    check("t1_drain", m_valid_a, 0);

    // backpressure for 3 cycles mid-packet
    tvalid_a = 3'b010; da[1] = 8'hB1;
    tick;
    tick;
    check("bp_d1", m_data_a, 8'hB1);
    da[1] = 8'hB2; m_ready_a = 1'b0;
    #1;
    check("bp_tready_hold", tready_a, 0);
    for (int c = 0; c < 3; c++) begin
      tick;
      check("bp_hold_data", m_data_a, 8'hB1);
      check("bp_hold_valid", m_valid_a, 1);
      check("bp_hold_tready", tready_a, 0);
    end
    m_ready_a = 1'b1;
    #1;
    check("bp_tready_rel", tready_a, 3'b010);
    tick;
    check("bp_d2", m_data_a, 8'hB2);
    da[1] = 8'hB3; tlast_a = 3'b010;
    tick;
    check("bp_d3", m_data_a, 8'hB3);
    check("bp_last3", m_last_a, 1);
    tvalid_a = '0; tlast_a = '0;
    tick;
    check("bp_drain", m_valid_a, 0);

    // sel moves 1->2 during a channel-1 packet
    tvalid_a = 3'b110; da[1] = 8'hC1; da[2] = 8'hD1;
    tick;
    tick;
    check("sw_c1", m_data_a, 8'hC1);
    sel_a = 2'd2; da[1] = 8'hC2; tlast_a = 3'b010;
    tick;
    check("sw_c2", m_data_a, 8'hC2);
    check("sw_c2_tid", m_tid_a, 1);
    check("sw_c2_last", m_last_a, 1);
    tvalid_a = 3'b100; tlast_a = 3'b000;
    tick;
    check("sw_bubble", m_valid_a, 0);
    check("sw_busy2", busy_a, 1);
    tick;
    check("sw_d1", m_data_a, 8'hD1);
    check("sw_d1_tid", m_tid_a, 2);
    da[2] = 8'hD2; tlast_a = 3'b100;
    tick;
    check("sw_d2", m_data_a, 8'hD2);
    check("sw_d2_last", m_last_a, 1);
    tvalid_a = '0; tlast_a = '0;
    tick;

    // sel beyond the channel count never grants
    sel_a = 2'd3; tvalid_a = 3'b111;
    for (int c = 0; c < 3; c++) begin
      tick;
      check("inv_busy", busy_a, 0);
      check("inv_tready", tready_a, 0);
      check("inv_valid", m_valid_a, 0);
    end
    tvalid_a = '0;

    // round-robin with every channel continuously offering 2-beat packets
    for (int p = 0; p < 5; p++) begin
      for (int b = 0; b < 2; b++) begin
        exp_q.push_back({4'(p % 4), 4'(b)});
        tid_exp.push_back(2'(p % 4));
      end
    end
    tvalid_b = 4'hF;
    drive_b();
    #1;
    pre = tready_b;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
      tick;
      if (m_valid_b) begin
        dat_got.push_back(m_data_b);
        tid_got.push_back(m_tid_b);
        got++;
      end
      for (int i = 0; i < 4; i++) if (pre[i]) phase[i] = ~phase[i];
      drive_b();
      #1;
      pre = tready_b;
      check("rr_onehot", 32'($countones(pre) <= 1), 1);
    end
    check("rr_count", got, 10);
    for (int k = 0; k < 10 && k < got; k++) begin
      check("rr_tid", tid_got[k], tid_exp[k]);
      check("rr_data", dat_got[k], exp_q[k]);
    end

    // asynchronous reset in the middle of traffic
    #2;
    areset = 1'b1;
    #1;
    check("ar_valid", m_valid_b, 0);
    check("ar_busy", busy_b, 0);
    check("ar_tready", tready_b, 0);
    check("ar_data", m_data_b, 0);
    check("ar_tid", m_tid_b, 0);
    check("ar_last", m_last_b, 0);
    tick;
    areset = 1'b0;
    for (int i = 0; i < 4; i++) phase[i] = 1'b0;
    drive_b();
    tick;
    check("ar_grant_busy", busy_b, 1);
    tick;
    check("ar_first_valid", m_valid_b, 1);
    check("ar_first_tid", m_tid_b, 0);
    check("ar_first_data", m_data_b, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
